// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one downstream memory port between the instruction
// fetch requester (I) and the load/store requester (D). It allows one
// transaction in flight at a time. D has priority, and a starvation counter
// guarantees that I is granted after a bounded number of consecutive losses.
module mem_bus_arbiter #(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic                  i_ok,
    output logic [DATA_W-1:0]     i_rdata,
    input  logic                  d_valid,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic                  d_write,
    input  logic [DATA_W/8-1:0]   d_strobe,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic                  d_ok,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  m_valid,
    output logic [ADDR_W-1:0]     m_addr,
    output logic                  m_write,
    output logic [DATA_W/8-1:0]   m_strobe,
    output logic [DATA_W-1:0]     m_wdata,
    input  logic                  m_ready,
    input  logic                  m_rvalid,
    input  logic [DATA_W-1:0]     m_rdata,
    output logic                  stray_resp
);

    localparam int STRB_W = DATA_W / 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [1:0]        state_reg,  state_next;
    logic              owner_reg,  owner_next;    // 1 = D owns the transaction
    logic [3:0]        starve_reg, starve_next;
    logic [ADDR_W-1:0] addr_reg,   addr_next;
    logic              write_reg,  write_next;
    logic [STRB_W-1:0] strobe_reg, strobe_next;
    logic [DATA_W-1:0] wdata_reg,  wdata_next;
    logic [DATA_W-1:0] i_rdata_reg;
    logic [DATA_W-1:0] d_rdata_reg;
    logic              grant_d;

    // Arbitration, request latching and transaction sequencing.
    always_comb begin
        state_next  = state_reg;
        owner_next  = owner_reg;
        starve_next = starve_reg;
        addr_next   = addr_reg;
        write_next  = write_reg;
        strobe_next = strobe_reg;
        wdata_next  = wdata_reg;
        grant_d     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (i_valid || d_valid) begin
                    // D wins unless I has already lost STARVE_LIMIT times in a row.
                    grant_d    = d_valid && !(i_valid && (starve_reg == LIMIT));
                    state_next = ST_ISSUE;
                    owner_next = grant_d;
                    if (grant_d) begin
                        addr_next   = d_addr;
                        write_next  = d_write;
                        strobe_next = d_strobe;
                        wdata_next  = d_wdata;
                        // A D win with I waiting is one more lost round for I.
                        if (i_valid && (starve_reg != LIMIT)) begin
                            starve_next = starve_reg + 4'd1;
                        end
                    end else begin
                        // Fetches never write.
                        addr_next   = i_addr;
                        write_next  = 1'b0;
                        strobe_next = '0;
                        wdata_next  = '0;
                        starve_next = 4'd0;
                    end
                end
            end
            ST_ISSUE: begin
                if (m_ready) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (m_rvalid) begin
                    state_next = ST_DONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and latched-request registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= ST_IDLE;
            owner_reg  <= 1'b0;
            starve_reg <= 4'd0;
            addr_reg   <= '0;
            write_reg  <= 1'b0;
            strobe_reg <= '0;
            wdata_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            owner_reg  <= owner_next;
            starve_reg <= starve_next;
            addr_reg   <= addr_next;
            write_reg  <= write_next;
            strobe_reg <= strobe_next;
            wdata_reg  <= wdata_next;
        end
    end

    // Capture the response into the owner's read-data register. The value holds until that owner's next response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_rdata_reg <= '0;
            d_rdata_reg <= '0;
        end else if ((state_reg == ST_WAIT) && m_rvalid) begin
            if (owner_reg) begin
                d_rdata_reg <= m_rdata;
            end else begin
                i_rdata_reg <= m_rdata;
            end
        end
    end

    assign m_valid  = (state_reg == ST_ISSUE);
    assign m_addr   = addr_reg;
    assign m_write  = write_reg;
    assign m_strobe = strobe_reg;
    assign m_wdata  = wdata_reg;

    assign i_ok    = (state_reg == ST_DONE) && !owner_reg;
    assign d_ok    = (state_reg == ST_DONE) &&  owner_reg;
    assign i_rdata = i_rdata_reg;
    assign d_rdata = d_rdata_reg;

    // A response while no transaction is awaiting one is flagged.
    // The flag is kept low while reset is asserted.
    assign stray_resp = rst && m_rvalid &&
                        ((state_reg == ST_IDLE) || (state_reg == ST_ISSUE));

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed scenarios followed by randomized traffic.
// Checks use a transaction-level reference model of the arbitration rules.
module tb_mem_bus_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic [63:0] i_addr;
    logic        i_ok;
    logic [63:0] i_rdata;
    logic        d_valid;
    logic [63:0] d_addr;
    logic        d_write;
    logic [7:0]  d_strobe;
    logic [63:0] d_wdata;
    logic        d_ok;
    logic [63:0] d_rdata;
    logic        m_valid;
    logic [63:0] m_addr;
    logic        m_write;
    logic [7:0]  m_strobe;
    logic [63:0] m_wdata;
    logic        m_ready;
    logic        m_rvalid;
    logic [63:0] m_rdata;
    logic        stray_resp;

    mem_bus_arbiter #(.ADDR_W(64), .DATA_W(64), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .i_addr(i_addr), .i_ok(i_ok), .i_rdata(i_rdata),
        .d_valid(d_valid), .d_addr(d_addr), .d_write(d_write), .d_strobe(d_strobe),
        .d_wdata(d_wdata), .d_ok(d_ok), .d_rdata(d_rdata),
        .m_valid(m_valid), .m_addr(m_addr), .m_write(m_write), .m_strobe(m_strobe),
        .m_wdata(m_wdata), .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .stray_resp(stray_resp)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_txn    = 0;

    // Reference model: each requester's pending request and the starvation count.
    bit          i_pend, d_pend;
    logic [63:0] i_a, d_a, d_wd;
    logic        d_w;
    logic [7:0]  d_s;
    logic [63:0] exp_i_rd, exp_d_rd;
    int          starve;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete transaction, starting from an idle cycle. Parameters:
    //   stall  - cycles to hold m_ready low before acceptance.
    //   wdelay - extra cycles before the response arrives.
    //   strays - inject m_rvalid pulses while the request is being issued.
    //   scramble - change the winner's live inputs after they have been sampled.
    task automatic run_txn(input int stall, input int wdelay, input bit scramble,
                           input bit strays, input logic [63:0] resp, output bit saw_d_ok);
        bit          win_d;
        bit          rv;
        logic [63:0] ea, ewd;
        logic        ew;
        logic [7:0]  es;
        win_d = d_pend && !(i_pend && (starve == LIMIT));
        if (i_pend && d_pend && win_d) starve = (starve + 1 > LIMIT) ? LIMIT : starve + 1;
        else if (!win_d) starve = 0;
        if (win_d) begin
            ea = d_a; ew = d_w; es = d_s; ewd = d_wd;
        end else begin
            ea = i_a; ew = 1'b0; es = 8'h00; ewd = 64'h0;
        end
        // Idle / arbitration cycle.
        @(negedge clk);
        i_valid = i_pend; i_addr = i_a;
        d_valid = d_pend; d_addr = d_a; d_write = d_w; d_strobe = d_s; d_wdata = d_wd;
        m_ready = 1'b0; m_rvalid = 1'b0;
        #1;
        chk1("idle_m_valid", m_valid, 1'b0);
        chk1("idle_i_ok", i_ok, 1'b0);
        chk1("idle_d_ok", d_ok, 1'b0);
        // Issue phase.
        for (int s = 0; s <= stall; s++) begin
            @(negedge clk);
            m_ready  = (s == stall);
            rv       = strays && ($urandom_range(0, 1) == 1);
            m_rvalid = rv;
            m_rdata  = {$urandom, $urandom};
            if (scramble) begin
                if (win_d) begin
                    d_addr = d_a + 64'h1000; d_write = ~d_w; d_strobe = ~d_s; d_wdata = ~d_wd;
                end else begin
                    i_addr = i_a + 64'h1000;
                end
            end
            #1;
            chk1("issue_m_valid", m_valid, 1'b1);
            chk64("issue_m_addr", m_addr, ea);
            chk1("issue_m_write", m_write, ew);
            chk64("issue_m_strobe", {56'h0, m_strobe}, {56'h0, es});
            if (win_d) chk64("issue_m_wdata", m_wdata, ewd);
            chk1("issue_stray", stray_resp, rv);
            chk1("issue_i_ok", i_ok, 1'b0);
            chk1("issue_d_ok", d_ok, 1'b0);
        end
        // Wait phase, ending with the response cycle.
        for (int w = 0; w <= wdelay; w++) begin
            @(negedge clk);
            m_ready  = 1'b0;
            m_rvalid = (w == wdelay);
            m_rdata  = (w == wdelay) ? resp : {$urandom, $urandom};
            #1;
            chk1("wait_m_valid", m_valid, 1'b0);
            chk1("wait_stray", stray_resp, 1'b0);
            chk1("wait_i_ok", i_ok, 1'b0);
            chk1("wait_d_ok", d_ok, 1'b0);
        end
        // Completion cycle.
        @(negedge clk);
        m_rvalid = 1'b0;
        m_rdata  = {$urandom, $urandom};
        if (win_d) begin
            d_valid = 1'b0; d_pend = 1'b0; exp_d_rd = resp;
        end else begin
            i_valid = 1'b0; i_pend = 1'b0; exp_i_rd = resp;
        end
        #1;
        chk1("done_i_ok", i_ok, !win_d);
        chk1("done_d_ok", d_ok, win_d);
        chk64("done_i_rdata", i_rdata, exp_i_rd);
        chk64("done_d_rdata", d_rdata, exp_d_rd);
        chk1("done_m_valid", m_valid, 1'b0);
        chk1("done_stray", stray_resp, 1'b0);
        saw_d_ok = d_ok;
        n_txn++;
        $display("txn %0d: owner=%s addr=%h write=%0d stall=%0d wait=%0d starve=%0d",
                 n_txn, win_d ? "D" : "I", ea, ew, stall, wdelay, starve);
    endtask

    initial begin
        bit exp_order[6];
        bit sd;
        exp_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

        // Reset.
        rst = 1'b0;
        i_valid = 1'b0; i_addr = '0;
        d_valid = 1'b0; d_addr = '0; d_write = 1'b0; d_strobe = '0; d_wdata = '0;
        m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
        i_pend = 0; d_pend = 0; i_a = '0; d_a = '0; d_wd = '0; d_w = 0; d_s = '0;
        exp_i_rd = '0; exp_d_rd = '0; starve = 0;
        repeat (2) @(negedge clk);
        #1;
        chk1("rst_m_valid", m_valid, 1'b0);
        chk64("rst_m_addr", m_addr, 64'h0);
        chk1("rst_i_ok", i_ok, 1'b0);
        chk1("rst_d_ok", d_ok, 1'b0);
        chk64("rst_i_rdata", i_rdata, 64'h0);
        chk64("rst_d_rdata", d_rdata, 64'h0);
        chk1("rst_stray", stray_resp, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // Single I fetch, minimum latency.
        i_pend = 1; i_a = 64'h0000_0000_8000_0000;
        run_txn(0, 0, 0, 0, 64'h0000_0013_0000_0093, sd);

        // D store with m_ready stalled three cycles.
        d_pend = 1; d_a = 64'h100; d_w = 1; d_s = 8'h0F; d_wd = 64'hDEAD_BEEF;
        run_txn(3, 0, 0, 0, {$urandom, $urandom}, sd);

        // Stray response while idle.
        @(negedge clk);
        m_rvalid = 1'b1;
        #1;
        chk1("stray_idle", stray_resp, 1'b1);
        chk1("stray_i_ok", i_ok, 1'b0);
        chk1("stray_d_ok", d_ok, 1'b0);
        chk1("stray_m_valid", m_valid, 1'b0);
        @(negedge clk);
        m_rvalid = 1'b0;
        #1;
        chk1("stray_pulse_end", stray_resp, 1'b0);
        chk1("stray_still_idle", m_valid, 1'b0);

        // I address changes after sampling; m_addr must keep 0x1000.
        i_pend = 1; i_a = 64'h1000;
        run_txn(2, 1, 1, 0, {$urandom, $urandom}, sd);

        // Contention: both requesters re-request continuously.
        i_a = 64'h2_0000; d_a = 64'h3_0000; d_w = 0; d_s = 8'h00; d_wd = 64'h0;
        for (int k = 0; k < 6; k++) begin
            i_pend = 1; d_pend = 1;
            run_txn(0, 0, 0, 0, {$urandom, $urandom}, sd);
            chk1("starve_grant", sd, exp_order[k]);
        end
        i_pend = 0; d_pend = 0;

        // Reset asserted while waiting for a response.
        @(negedge clk);
        i_valid = 1'b1; i_addr = 64'h4000;
        #1;
        @(negedge clk);
        m_ready = 1'b1;
        #1;
        chk1("rstw_issue", m_valid, 1'b1);
        @(negedge clk);
        m_ready = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk1("rstw_m_valid", m_valid, 1'b0);
        chk1("rstw_i_ok", i_ok, 1'b0);
        chk1("rstw_d_ok", d_ok, 1'b0);
        chk64("rstw_i_rdata", i_rdata, 64'h0);
        chk64("rstw_d_rdata", d_rdata, 64'h0);
        chk64("rstw_m_addr", m_addr, 64'h0);
        @(negedge clk);
        rst = 1'b1; i_valid = 1'b0;
        #1;
        chk1("rstw_after_m_valid", m_valid, 1'b0);
        @(negedge clk);
        m_rvalid = 1'b1;
        #1;
        chk1("rstw_late_stray", stray_resp, 1'b1);
        chk1("rstw_late_i_ok", i_ok, 1'b0);
        @(negedge clk);
        m_rvalid = 1'b0;
        starve = 0; exp_i_rd = '0; exp_d_rd = '0;
        i_pend = 1; i_a = 64'h5000;
        run_txn(1, 0, 0, 0, {$urandom, $urandom}, sd);

        // Randomized traffic.
        for (int n = 0; n < 150; n++) begin
            if (!i_pend && ($urandom_range(0, 1) == 1)) begin
                i_pend = 1; i_a = {$urandom, $urandom};
            end
            if (!d_pend && ($urandom_range(0, 1) == 1)) begin
                d_pend = 1; d_a = {$urandom, $urandom}; d_w = 1'($urandom_range(0, 1));
                d_s = 8'($urandom); d_wd = {$urandom, $urandom};
            end
            if (!i_pend && !d_pend) begin
                @(negedge clk);
                i_valid = 1'b0; d_valid = 1'b0;
                m_rvalid = 1'($urandom_range(0, 1));
                #1;
                chk1("rand_idle_stray", stray_resp, m_rvalid);
                chk1("rand_idle_m_valid", m_valid, 1'b0);
                @(negedge clk);
                m_rvalid = 1'b0;
            end else begin
                run_txn(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        {$urandom, $urandom}, sd);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
